// File: rtl/cam2sdram_wr.sv
// Camera-to-SDRAM write buffer: pixel FIFO feeding fixed-length SDRAM write bursts.
// Build macro CAM2SDRAM_TESTPAT_EN replaces pushed pixel data with an incrementing pattern.
module cam2sdram_wr #(
    parameter int DATA_W      = 16,
    parameter int DEPTH       = 512,
    parameter int BURST_LEN   = 256,
    parameter int ADDR_W      = 22,
    parameter int FRAME_WORDS = 307200
) (
    input  logic                   clk_133M_i,
    input  logic                   rst_133i,
    input  logic                   pix_valid_i,
    input  logic [DATA_W-1:0]      pix_data_i,
    input  logic                   frame_start_i,
    output logic                   wr_req_o,
    input  logic                   wr_ack_i,
    output logic [ADDR_W-1:0]      wr_addr_o,
    output logic [DATA_W-1:0]      wr_data_o,
    output logic                   wr_data_en_o,
    output logic [$clog2(DEPTH):0] fifo_used_o,
    output logic                   overflow_o,
    output logic                   burst_busy_o
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BEAT_W = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_BURST} state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  rdata_q;
    logic               ovf_q, ovf_d;
    logic               pend_q, pend_d;

    logic               full;
    logic               accept;
    logic               last_beat;
    logic               flush_now;
    logic               push;
    logic               pop;
    logic               rd_en;
    logic               mem_we;
    logic [PTR_W-1:0]   mem_waddr;
    logic [PTR_W-1:0]   mem_raddr;
    logic [DATA_W-1:0]  push_data;
    logic [ADDR_W:0]    addr_sum;

    assign full      = (cnt_q == CNT_W'(DEPTH));
    assign accept    = pix_valid_i && !pend_q;
    assign last_beat = (beat_q == BEAT_W'(BURST_LEN - 1));
    assign addr_sum  = {1'b0, addr_q} + (ADDR_W + 1)'(BURST_LEN);

    assign wr_addr_o   = addr_q;
    assign wr_data_o   = rdata_q;
    assign fifo_used_o = cnt_q;
    assign overflow_o  = ovf_q;

`ifdef CAM2SDRAM_TESTPAT_EN
    logic [15:0]       pat_q, pat_d;
    logic [DATA_W-1:0] pix_unused;

    assign pix_unused = pix_data_i;
    // A pixel coinciding with an applied flush becomes word 0 of the new frame.
    assign push_data  = flush_now ? '0 : DATA_W'(pat_q);

    always_comb begin
        pat_d = pat_q;
        if (flush_now) begin
            pat_d = accept ? 16'd1 : 16'd0;
        end else if (push) begin
            pat_d = pat_q + 16'd1;
        end
    end

    always_ff @(posedge clk_133M_i) begin
        if (!rst_133i) begin
            pat_q <= '0;
        end else begin
            pat_q <= pat_d;
        end
    end
`else
    assign push_data = pix_data_i;
`endif

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        beat_d       = beat_q;
        addr_d       = addr_q;
        ovf_d        = ovf_q;
        pend_d       = pend_q;
        flush_now    = 1'b0;
        push         = 1'b0;
        pop          = 1'b0;
        rd_en        = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = wr_ptr_q;
        mem_raddr    = rd_ptr_q;
        wr_req_o     = (state_q == ST_REQ);
        wr_data_en_o = (state_q == ST_BURST);
        burst_busy_o = (state_q != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                if (frame_start_i) begin
                    flush_now = 1'b1;
                end else if (cnt_q >= CNT_W'(BURST_LEN)) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (wr_ack_i) begin
                    // Prefetch word 0 so it is on the bus in the first burst cycle.
                    state_d = ST_BURST;
                    beat_d  = '0;
                    rd_en   = 1'b1;
                    if (frame_start_i) pend_d = 1'b1;
                end else if (frame_start_i) begin
                    state_d   = ST_IDLE;
                    flush_now = 1'b1;
                end
            end
            ST_BURST: begin
                pop       = 1'b1;
                rd_en     = !last_beat;
                mem_raddr = rd_ptr_q + PTR_W'(1);
                beat_d    = beat_q + BEAT_W'(1);
                if (frame_start_i) pend_d = 1'b1;
                if (last_beat) begin
                    state_d = ST_IDLE;
                    if (pend_q || frame_start_i) begin
                        flush_now = 1'b1;
                    end else if (addr_sum >= (ADDR_W + 1)'(FRAME_WORDS)) begin
                        addr_d = '0;
                    end else begin
                        addr_d = addr_sum[ADDR_W-1:0];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush_now) begin
            rd_ptr_d = '0;
            addr_d   = '0;
            ovf_d    = 1'b0;
            pend_d   = 1'b0;
            if (accept) begin
                mem_we    = 1'b1;
                mem_waddr = '0;
                wr_ptr_d  = PTR_W'(1);
                cnt_d     = CNT_W'(1);
            end else begin
                wr_ptr_d  = '0;
                cnt_d     = '0;
            end
        end else begin
            push = accept && !full;
            if (accept && full) ovf_d = 1'b1;
            if (push) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_133M_i) begin
        if (!rst_133i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_133M_i) begin
        if (!rst_133i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            beat_q   <= '0;
            addr_q   <= '0;
            ovf_q    <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            beat_q   <= beat_d;
            addr_q   <= addr_d;
            ovf_q    <= ovf_d;
            pend_q   <= pend_d;
        end
    end

    always_ff @(posedge clk_133M_i) begin
        if (mem_we) mem_q[mem_waddr] <= push_data;
    end

    always_ff @(posedge clk_133M_i) begin
        if (!rst_133i) begin
            rdata_q <= '0;
        end else if (rd_en) begin
            rdata_q <= mem_q[mem_raddr];
        end
    end
endmodule
